// File: rtl/cci_rd_arbiter_nport.sv
// N-client round-robin read-request arbiter in front of the single CCI c0 read channel.
// Requests carry the client index in the upper mdata bits; responses are routed back by that tag.
module cci_rd_arbiter_nport #(
  parameter int N_CLIENTS       = 4,
  parameter int ADDR_WIDTH      = 42,
  parameter int MDATA_WIDTH     = 16,
  parameter int DATA_WIDTH      = 512,
  parameter int MAX_OUTSTANDING = 64,
  localparam int TAG_BITS       = $clog2(N_CLIENTS),
  localparam int CL_MDATA       = MDATA_WIDTH - TAG_BITS
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [N_CLIENTS-1:0]           cl_req_valid,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0] cl_req_addr,
  input  logic [N_CLIENTS*CL_MDATA-1:0]  cl_req_mdata,
  output logic [N_CLIENTS-1:0]           cl_req_ready,
  output logic                           fiu_req_valid,
  output logic [ADDR_WIDTH-1:0]          fiu_req_addr,
  output logic [MDATA_WIDTH-1:0]         fiu_req_mdata,
  input  logic                           fiu_c0_almost_full,
  input  logic                           fiu_rsp_valid,
  input  logic [MDATA_WIDTH-1:0]         fiu_rsp_mdata,
  input  logic [DATA_WIDTH-1:0]          fiu_rsp_data,
  output logic [N_CLIENTS-1:0]           cl_rsp_valid,
  output logic [CL_MDATA-1:0]            cl_rsp_mdata,
  output logic [DATA_WIDTH-1:0]          cl_rsp_data,
  output logic                           idle,
  output logic                           tag_error
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic                 afReg;
  logic [TAG_BITS-1:0]  rrPtr;
  logic [CNT_W-1:0]     outCnt [N_CLIENTS];
  logic [N_CLIENTS-1:0] eligible;
  logic                 anyGrant;
  logic [TAG_BITS-1:0]  grantIdx;
  int                   probe;
  logic [TAG_BITS-1:0]  rspTag;
  logic                 rspTagOk;
  logic [N_CLIENTS-1:0] rspOh;
  logic                 cntAllZero;

  // Handshake: a client request transfers in the cycle where cl_req_valid[i] && cl_req_ready[i];
  // ready is a one-hot grant that depends on valid only through eligibility, and a client keeps
  // valid asserted until that transfer happens.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      eligible[i] = reset_n && !afReg && cl_req_valid[i] && (outCnt[i] < MAX_CNT);
    end
  end

  // First eligible client at or above the round-robin pointer, wrapping around.
  always_comb begin
    anyGrant = 1'b0;
    grantIdx = '0;
    probe    = 0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      probe = int'(rrPtr) + k;
      if (probe >= N_CLIENTS) probe = probe - N_CLIENTS;
      if (!anyGrant && eligible[probe]) begin
        anyGrant = 1'b1;
        grantIdx = TAG_BITS'(probe);
      end
    end
  end

  assign cl_req_ready = anyGrant ? (N_CLIENTS'(1) << grantIdx) : '0;

  assign rspTag   = fiu_rsp_mdata[MDATA_WIDTH-1 -: TAG_BITS];
  assign rspTagOk = int'(rspTag) < N_CLIENTS;
  assign rspOh    = (fiu_rsp_valid && rspTagOk) ? (N_CLIENTS'(1) << rspTag) : '0;

  always_comb begin
    cntAllZero = 1'b1;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (outCnt[i] != '0) cntAllZero = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      afReg         <= 1'b0;
      rrPtr         <= '0;
      fiu_req_valid <= 1'b0;
      fiu_req_addr  <= '0;
      fiu_req_mdata <= '0;
      cl_rsp_valid  <= '0;
      cl_rsp_mdata  <= '0;
      cl_rsp_data   <= '0;
      idle          <= 1'b0;
      tag_error     <= 1'b0;
      for (int i = 0; i < N_CLIENTS; i++) outCnt[i] <= '0;
    end else begin
      afReg         <= fiu_c0_almost_full;
      fiu_req_valid <= anyGrant;
      if (anyGrant) begin
        fiu_req_addr  <= cl_req_addr[grantIdx*ADDR_WIDTH +: ADDR_WIDTH];
        fiu_req_mdata <= {grantIdx, cl_req_mdata[grantIdx*CL_MDATA +: CL_MDATA]};
        rrPtr         <= (int'(grantIdx) == N_CLIENTS - 1) ? '0 : grantIdx + 1'b1;
      end
      cl_rsp_valid <= rspOh;
      if (fiu_rsp_valid) begin
        cl_rsp_mdata <= fiu_rsp_mdata[CL_MDATA-1:0];
        cl_rsp_data  <= fiu_rsp_data;
      end
      tag_error <= tag_error | (fiu_rsp_valid && !rspTagOk);
      idle      <= !fiu_req_valid && cntAllZero;
      // A grant and a response for the same client in one cycle cancel out.
      for (int i = 0; i < N_CLIENTS; i++) begin
        case ({cl_req_ready[i], rspOh[i]})
          2'b10:   if (outCnt[i] != MAX_CNT) outCnt[i] <= outCnt[i] + CNT_W'(1);
          2'b01:   if (outCnt[i] != '0) outCnt[i] <= outCnt[i] - CNT_W'(1);
          default: outCnt[i] <= outCnt[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cci_rd_arbiter_nport.sv
// Directed bench for cci_rd_arbiter_nport: a 4-client instance with a limit of 4 in flight,
// plus a 3-client instance used to exercise out-of-range response tags.
module tb_cci_rd_arbiter_nport;

  localparam int AW = 16;
  localparam int MW = 16;
  localparam int DW = 32;
  localparam int CLM = 14;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  // 4-client instance
  logic [3:0]      cl_req_valid = '0;
  logic [4*AW-1:0] cl_req_addr  = '0;
  logic [4*CLM-1:0] cl_req_mdata = '0;
  logic [3:0]      cl_req_ready;
  logic            fiu_req_valid;
  logic [AW-1:0]   fiu_req_addr;
  logic [MW-1:0]   fiu_req_mdata;
  logic            fiu_c0_almost_full = 1'b0;
  logic            fiu_rsp_valid = 1'b0;
  logic [MW-1:0]   fiu_rsp_mdata = '0;
  logic [DW-1:0]   fiu_rsp_data  = '0;
  logic [3:0]      cl_rsp_valid;
  logic [CLM-1:0]  cl_rsp_mdata;
  logic [DW-1:0]   cl_rsp_data;
  logic            idle;
  logic            tag_error;

  // 3-client instance
  logic [2:0]       b_req_valid = '0;
  logic [3*AW-1:0]  b_req_addr  = '0;
  logic [3*CLM-1:0] b_req_mdata = '0;
  logic [2:0]       b_req_ready;
  logic             b_fiu_req_valid;
  logic [AW-1:0]    b_fiu_req_addr;
  logic [MW-1:0]    b_fiu_req_mdata;
  logic             b_rsp_valid = 1'b0;
  logic [MW-1:0]    b_rsp_mdata = '0;
  logic [DW-1:0]    b_rsp_data  = '0;
  logic [2:0]       b_cl_rsp_valid;
  logic [CLM-1:0]   b_cl_rsp_mdata;
  logic [DW-1:0]    b_cl_rsp_data;
  logic             b_idle;
  logic             b_tag_error;

  cci_rd_arbiter_nport #(
    .N_CLIENTS(4), .ADDR_WIDTH(AW), .MDATA_WIDTH(MW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cl_req_valid(cl_req_valid), .cl_req_addr(cl_req_addr), .cl_req_mdata(cl_req_mdata),
    .cl_req_ready(cl_req_ready),
    .fiu_req_valid(fiu_req_valid), .fiu_req_addr(fiu_req_addr), .fiu_req_mdata(fiu_req_mdata),
    .fiu_c0_almost_full(fiu_c0_almost_full),
    .fiu_rsp_valid(fiu_rsp_valid), .fiu_rsp_mdata(fiu_rsp_mdata), .fiu_rsp_data(fiu_rsp_data),
    .cl_rsp_valid(cl_rsp_valid), .cl_rsp_mdata(cl_rsp_mdata), .cl_rsp_data(cl_rsp_data),
    .idle(idle), .tag_error(tag_error)
  );

  cci_rd_arbiter_nport #(
    .N_CLIENTS(3), .ADDR_WIDTH(AW), .MDATA_WIDTH(MW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(64)
  ) dut_b (
    .clk(clk), .reset_n(reset_n),
    .cl_req_valid(b_req_valid), .cl_req_addr(b_req_addr), .cl_req_mdata(b_req_mdata),
    .cl_req_ready(b_req_ready),
    .fiu_req_valid(b_fiu_req_valid), .fiu_req_addr(b_fiu_req_addr), .fiu_req_mdata(b_fiu_req_mdata),
    .fiu_c0_almost_full(1'b0),
    .fiu_rsp_valid(b_rsp_valid), .fiu_rsp_mdata(b_rsp_mdata), .fiu_rsp_data(b_rsp_data),
    .cl_rsp_valid(b_cl_rsp_valid), .cl_rsp_mdata(b_cl_rsp_mdata), .cl_rsp_data(b_cl_rsp_data),
    .idle(b_idle), .tag_error(b_tag_error)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [AW+MW-1:0] exp_q[$];

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_ready;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] cli_addr(input int i);
    return 16'h1000 + 16'(i) * 16'h0111;
  endfunction

  function automatic logic [CLM-1:0] cli_mdata(input int i);
    return 14'h0100 + 14'(i);
  endfunction

  function automatic int oh_idx(input logic [3:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    cl_req_valid = '0;
    fiu_rsp_valid = 1'b0;
    fiu_c0_almost_full = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Holds client-0 valid for n cycles and returns how many grants it received.
  task automatic count_grants0(input int n, output int grants);
    grants = 0;
    cl_req_valid = 4'b0001;
    for (int c = 0; c < n; c++) begin
      #1;
      if (cl_req_ready[0]) grants++;
      tick();
    end
  endtask

  initial begin
    int grants;
    int pulses;
    logic [AW+MW-1:0] e;

    for (int i = 0; i < 4; i++) begin
      cl_req_addr[i*AW +: AW]   = cli_addr(i);
      cl_req_mdata[i*CLM +: CLM] = cli_mdata(i);
    end

    // Arbitration table; expected grants hand-derived from RR pointer and a limit of 4.
    vecs[0]  = '{4'b1111, 4'b0001};
    vecs[1]  = '{4'b1111, 4'b0010};
    vecs[2]  = '{4'b1111, 4'b0100};
    vecs[3]  = '{4'b1111, 4'b1000};
    vecs[4]  = '{4'b1111, 4'b0001};
    vecs[5]  = '{4'b0000, 4'b0000};
    vecs[6]  = '{4'b1001, 4'b1000};
    vecs[7]  = '{4'b1001, 4'b0001};
    vecs[8]  = '{4'b0101, 4'b0100};
    vecs[9]  = '{4'b0011, 4'b0001};
    vecs[10] = '{4'b0001, 4'b0000};
    vecs[11] = '{4'b0011, 4'b0010};

    // reset state
    tick();
    tick();
    chk("rst_ready", cl_req_ready, 0);
    chk("rst_fiu_valid", fiu_req_valid, 0);
    chk("rst_rsp_valid", cl_rsp_valid, 0);
    chk("rst_idle", idle, 0);
    chk("rst_tag_error", tag_error, 0);
    reset_n = 1'b1;
    tick();
    chk("idle_after_release", idle, 1);

    // table-driven arbitration
    for (int r = 0; r < 12; r++) begin
      cl_req_valid = vecs[r].valid;
      #1;
      chk($sformatf("tbl%0d_ready", r), cl_req_ready, vecs[r].exp_ready);
      if (vecs[r].exp_ready != 0) begin
        exp_q.push_back({cli_addr(oh_idx(vecs[r].exp_ready)),
                         2'(oh_idx(vecs[r].exp_ready)), cli_mdata(oh_idx(vecs[r].exp_ready))});
      end
      tick();
      chk($sformatf("tbl%0d_fiu_valid", r), fiu_req_valid, (vecs[r].exp_ready != 0));
      if (fiu_req_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tbl%0d_unexpected_req: got addr %0h expected none", r, fiu_req_addr);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("tbl%0d_fiu_req", r), {fiu_req_addr, fiu_req_mdata}, e);
        end
      end
    end

    // reset mid-traffic with clients still requesting
    cl_req_valid = 4'b1111;
    #1;
    chk("busy_not_idle", idle, 0);
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", cl_req_ready, 0);
    chk("midrst_fiu_valid", fiu_req_valid, 0);
    chk("midrst_fiu_addr", fiu_req_addr, 0);
    chk("midrst_idle", idle, 0);
    cl_req_valid = '0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("midrst_idle_after", idle, 1);

    // client 0 was at its limit before reset; a fresh count allows exactly 4 grants
    count_grants0(8, grants);
    chk("limit_grants", grants, 4);
    #1;
    chk("limit_ready_low", cl_req_ready, 0);
    fiu_rsp_valid = 1'b1;
    fiu_rsp_mdata = {2'd0, 14'h0011};
    tick();
    fiu_rsp_valid = 1'b0;
    chk("limit_rsp_route", cl_rsp_valid, 4'b0001);
    count_grants0(6, grants);
    chk("limit_one_more", grants, 1);

    // simultaneous grant and response on client 0
    cl_req_valid = '0;
    fiu_rsp_valid = 1'b1;
    fiu_rsp_mdata = {2'd0, 14'h0022};
    tick();
    cl_req_valid = 4'b0001;
    #1;
    chk("simul_ready", cl_req_ready, 4'b0001);
    tick();
    cl_req_valid = '0;
    fiu_rsp_valid = 1'b0;
    tick();
    count_grants0(6, grants);
    chk("simul_count_unchanged", grants, 1);

    // response routing and counter decrement on client 3
    do_reset();
    cl_req_valid = 4'b1000;
    #1;
    chk("route_ready3", cl_req_ready, 4'b1000);
    tick();
    cl_req_valid = '0;
    chk("route_req_tag", fiu_req_mdata, {2'd3, cli_mdata(3)});
    tick();
    chk("route_busy", idle, 0);
    fiu_rsp_valid = 1'b1;
    fiu_rsp_mdata = {2'd3, 14'h0ABC};
    fiu_rsp_data  = 32'hDEADBEEF;
    tick();
    fiu_rsp_valid = 1'b0;
    chk("route_valid", cl_rsp_valid, 4'b1000);
    chk("route_mdata", cl_rsp_mdata, 14'h0ABC);
    chk("route_data", cl_rsp_data, 32'hDEADBEEF);
    tick();
    chk("route_pulse", cl_rsp_valid, 0);
    chk("route_idle_again", idle, 1);

    // almost-full throttling
    do_reset();
    cl_req_valid = 4'b1111;
    repeat (3) tick();
    fiu_c0_almost_full = 1'b1;
    pulses = 0;
    tick();
    if (fiu_req_valid) pulses++;
    #1;
    chk("af_ready_blocked", cl_req_ready, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (fiu_req_valid) pulses++;
    end
    chk("af_pulses_in_slack", (pulses >= 1 && pulses <= 2), 1);
    fiu_c0_almost_full = 1'b0;
    #1;
    chk("af_release_lag", cl_req_ready, 0);
    tick();
    #1;
    chk("af_resume_ready", cl_req_ready, 4'b0001);
    tick();
    chk("af_resume_req", fiu_req_valid, 1);
    cl_req_valid = '0;

    // out-of-range tag on the 3-client instance
    chk("b_tag_error_init", b_tag_error, 0);
    b_rsp_valid = 1'b1;
    b_rsp_mdata = {2'd3, 14'h0055};
    tick();
    b_rsp_valid = 1'b0;
    chk("b_badtag_no_valid", b_cl_rsp_valid, 0);
    chk("b_tag_error_set", b_tag_error, 1);
    repeat (3) tick();
    chk("b_tag_error_sticky", b_tag_error, 1);
    b_rsp_valid = 1'b1;
    b_rsp_mdata = {2'd2, 14'h0066};
    tick();
    b_rsp_valid = 1'b0;
    chk("b_goodtag_route", b_cl_rsp_valid, 3'b100);
    chk("b_tag_error_held", b_tag_error, 1);
    chk("b_idle", b_idle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
